// File: rtl/mips_pkg.sv
// Shared types and defaults for the memory arbiter: FSM states, grant encoding
// and the default memory latency.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and stall signals around the memory arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_arbiter_if #(
    parameter int AW = 32
);
    // Handshake: a requester raises *_req with stable addr/we/wdata and holds
    // them until its *_ack pulses for one cycle; the ack cycle also carries
    // valid *_rdata for reads. Dropping req early does not cancel a started
    // transaction.
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic          d_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          if_stall;
    logic          d_stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, if_stall, d_stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, if_stall, d_stall
    );

endinterface

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency down-counter: load has priority over decrement; zero flags
// the last BUSY cycle.
module mem_arb_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto one memory port.
// Define MEM_ARB_RR_EN for round-robin on collisions; otherwise data wins.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = 32
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output state_t         dbg_state
);

    state_t        state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          any_req;
    logic          launch;
    gnt_t          pick;
    logic          cnt_load, cnt_dec, cnt_zero;

`ifdef MEM_ARB_RR_EN
    gnt_t          last_q, last_d;
`endif

    assign any_req = bus.if_req | bus.d_req;

    always_comb begin
        pick = GNT_D;
        if (bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
            pick = (last_q == GNT_D) ? GNT_IF : GNT_D;
`else
            pick = GNT_D;
`endif
        end else if (bus.if_req) begin
            pick = GNT_IF;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        launch     = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: launch = any_req;
            BUSY: begin
                if (cnt_zero) begin
                    state_d = ACK;
                    if (gnt_q == GNT_IF) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ACK: begin
                // Re-arbitrate here so back-to-back requests skip IDLE.
                launch  = any_req;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d  = BUSY;
            gnt_d    = pick;
            cnt_load = 1'b1;
            addr_d   = (pick == GNT_D) ? bus.d_addr : bus.if_addr;
            we_d     = (pick == GNT_D) & bus.d_we;
            wdata_d  = (pick == GNT_D) ? bus.d_wdata : '0;
`ifdef MEM_ARB_RR_EN
            last_d   = pick;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_D;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_q     <= GNT_D;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    mem_arb_lat_cnt #(.W(LAT_CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_CNT_W'(MEM_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign bus.mem_en    = (state_q == BUSY);
    assign bus.mem_we    = (state_q == BUSY) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = (state_q == ACK) & (gnt_q == GNT_IF);
    assign bus.d_ack     = (state_q == ACK) & (gnt_q == GNT_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~bus.if_ack;
    assign bus.d_stall   = bus.d_req & ~bus.d_ack;
    assign dbg_state     = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: memory read/write latency in cycles (1..15).
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports if_req (in, 1), if_addr (in, AW), if_rdata (out, 32), if_ack (out, 1): instruction-fetch requester.
REQ-006 SHALL have ports d_req (in, 1), d_we (in, 1), d_addr (in, AW), d_wdata (in, 32), d_rdata (out, 32), d_ack (out, 1): data requester.
REQ-007 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, AW), mem_wdata (out, 32), mem_rdata (in, 32): single shared memory port.
REQ-008 SHALL have ports if_stall, d_stall (out, 1): pipeline stall requests.

Function
REQ-009 SHALL use FSM states IDLE, BUSY, ACK.
REQ-010 IDLE: if any req high, SHALL latch grant, address, we, wdata at the clock edge and enter BUSY with counter = MEM_LAT-1.
REQ-011 BUSY: mem_en=1, mem_we/addr/wdata from latched values; counter decrements each cycle; at 0, SHALL capture mem_rdata into granted rdata register and enter ACK.
REQ-012 ACK: granted ack=1 for exactly one cycle, mem_en=0; SHALL arbitrate as in IDLE and enter BUSY directly if any req is high, else IDLE.
REQ-013 Latency: req sampled at edge N -> ack high in cycle N+MEM_LAT+1; back-to-back transactions SHALL have no idle cycle between ACK and next BUSY.
REQ-014 Fixed priority (macro absent): simultaneous requests SHALL grant data.
REQ-015 Requesters hold req/addr/wdata until ack; req deasserted during BUSY SHALL NOT abort: transaction completes, ack still pulses.
REQ-016 rdata outputs SHALL hold last captured value until the next completion for that requester; writes SHALL NOT update d_rdata.
REQ-017 if_stall = if_req & ~if_ack; d_stall = d_req & ~d_ack (combinational).
REQ-018 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-019 On reset: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=d_ack=0, if_rdata=d_rdata=0, counter=0, last-grant=DATA.
REQ-020 Reset asserted mid-BUSY SHALL abort immediately: mem_en low the same cycle, no ack issued after release.

Configuration
REQ-021 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL grant the requester not served last (last-grant flag updated on each grant); single request granted regardless.
REQ-022 Macro absent: last-grant flag not implemented; REQ-014 applies.

Structure
REQ-023 State enum, grant encoding (GNT_IF, GNT_D) and MEM_LAT default SHALL live in shared package mips_pkg.
REQ-024 The latency down-counter SHALL be sub-module mem_arb_lat_cnt (load, decrement, zero flag); everything else in mem_arbiter.

Verification (MEM_LAT=2)
REQ-025 if_req=1, if_addr=0x00000004 at edge 0, mem_rdata=0x8C020000 -> mem_en cycles 1-2, if_ack cycle 3, if_rdata=0x8C020000.
REQ-026 d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> mem_we=1 with mem_addr=0x10 for 2 cycles, d_ack once, d_rdata unchanged.
REQ-027 if_req and d_req both held high -> no macro: d_ack first and every grant to data while d_req high; MEM_ARB_RR_EN: grants alternate IF, D, IF, D.
REQ-028 Two back-to-back if_req -> acks in cycles 3 and 6, mem_en low only in ACK cycles.
REQ-029 reset pulsed in cycle 2 of BUSY -> all outputs at reset values, no ack, next request serviced normally.
REQ-030 if_req dropped in cycle 1 of BUSY -> if_ack still pulses cycle 3; if_stall low from cycle 1.
